// File: rtl/i2c_result_target.sv
// I2C target that exposes a five-digit BCD lag measurement and two host-writable config fields.
// Filtered SCL/SDA drive a byte-level FSM; multi-byte reads see a frozen copy of the measurement.
module i2c_result_target #(
  parameter logic [6:0] I2C_ADDR   = 7'h2A,
  parameter int         FILTER_LEN = 3,
  parameter logic [7:0] DEVICE_ID  = 8'h54
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic        result_valid,
  input  logic [19:0] result_bcd,
  output logic [2:0]  config_out,
  output logic        config_override,
  output logic        busy
);

  localparam int            CW       = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RACK      = 4'd8
  } state_t;

  function automatic logic [7:0] reg_mux(
    input logic [2:0]  sel,
    input logic [19:0] shadow,
    input logic        flag,
    input logic [2:0]  cfg,
    input logic        ovr
  );
    case (sel)
      3'd0:    reg_mux = shadow[7:0];
      3'd1:    reg_mux = shadow[15:8];
      3'd2:    reg_mux = {4'h0, shadow[19:16]};
      3'd3:    reg_mux = {7'h00, flag};
      3'd4:    reg_mux = {5'h00, cfg};
      3'd5:    reg_mux = {7'h00, ovr};
      3'd6:    reg_mux = DEVICE_ID;
      default: reg_mux = 8'h00;
    endcase
  endfunction

  logic          scl_meta_r, scl_sync_r, scl_f_r, scl_prev_r;
  logic          sda_meta_r, sda_sync_r, sda_f_r, sda_prev_r;
  logic [CW-1:0] scl_cnt_r, sda_cnt_r;
  logic          start_s, stop_s, scl_rise_s, scl_fall_s;

  state_t        state_r, state_n;
  logic          sda_oe_r, oe_n;
  logic          busy_r;
  logic [2:0]    ptr_r, ptr_n;
  logic [2:0]    bit_cnt_r, bit_cnt_n;
  logic [7:0]    rx_r, rx_n, rx_byte_s;
  logic [7:0]    tx_r, tx_n;
  logic [7:0]    rd_cur_s, rd_nxt_s;
  logic          wr_en_s, flag_clr_s, freeze_s;

  logic [2:0]    config_r;
  logic          override_r;
  logic [19:0]   shadow_r, pend_data_r;
  logic          pend_r, flag_r;

  // Two-flop synchronizers followed by run-length glitch filters on both bus lines
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      scl_f_r    <= 1'b1;
      sda_f_r    <= 1'b1;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
      scl_cnt_r  <= CNT_ZERO;
      sda_cnt_r  <= CNT_ZERO;
    end else begin
      scl_meta_r <= scl_in;
      scl_sync_r <= scl_meta_r;
      sda_meta_r <= sda_in;
      sda_sync_r <= sda_meta_r;
      scl_prev_r <= scl_f_r;
      sda_prev_r <= sda_f_r;
      if (scl_sync_r == scl_f_r) begin
        scl_cnt_r <= CNT_ZERO;
      end else if (scl_cnt_r == CNT_LAST) begin
        scl_f_r   <= scl_sync_r;
        scl_cnt_r <= CNT_ZERO;
      end else begin
        scl_cnt_r <= scl_cnt_r + CNT_ONE;
      end
      if (sda_sync_r == sda_f_r) begin
        sda_cnt_r <= CNT_ZERO;
      end else if (sda_cnt_r == CNT_LAST) begin
        sda_f_r   <= sda_sync_r;
        sda_cnt_r <= CNT_ZERO;
      end else begin
        sda_cnt_r <= sda_cnt_r + CNT_ONE;
      end
    end
  end

  assign start_s    = scl_f_r & scl_prev_r & sda_prev_r & ~sda_f_r;
  assign stop_s     = scl_f_r & scl_prev_r & ~sda_prev_r & sda_f_r;
  assign scl_rise_s = scl_f_r & ~scl_prev_r;
  assign scl_fall_s = ~scl_f_r & scl_prev_r;
  assign rx_byte_s  = {rx_r[6:0], sda_f_r};
  assign rd_cur_s   = reg_mux(ptr_r, shadow_r, flag_r, config_r, override_r);
  assign rd_nxt_s   = reg_mux(ptr_r + 3'd1, shadow_r, flag_r, config_r, override_r);

  // Next-state and bus-side control; ACK states drive on the first SCL fall, release on the second
  always_comb begin
    state_n    = state_r;
    oe_n       = sda_oe_r;
    ptr_n      = ptr_r;
    bit_cnt_n  = bit_cnt_r;
    rx_n       = rx_r;
    tx_n       = tx_r;
    wr_en_s    = 1'b0;
    flag_clr_s = 1'b0;
    if (stop_s) begin
      state_n = IDLE;
      oe_n    = 1'b0;
    end else if (start_s) begin
      state_n   = ADDR;
      oe_n      = 1'b0;
      bit_cnt_n = 3'd0;
    end else begin
      case (state_r)
        ADDR, PTR, WDATA: begin
          if (scl_rise_s) begin
            rx_n      = rx_byte_s;
            bit_cnt_n = bit_cnt_r + 3'd1;
            if (bit_cnt_r != 3'd7) begin
              state_n = state_r;
            end else if (state_r == ADDR) begin
              state_n = (rx_byte_s[7:1] == I2C_ADDR) ? ADDR_ACK : IDLE;
            end else if (state_r == PTR) begin
              ptr_n   = rx_byte_s[2:0];
              state_n = PTR_ACK;
            end else begin
              wr_en_s = 1'b1;
              state_n = WDATA_ACK;
            end
          end else begin
            state_n = state_r;
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (!scl_fall_s) begin
            state_n = state_r;
          end else if (!sda_oe_r) begin
            oe_n = 1'b1;
          end else begin
            oe_n      = 1'b0;
            bit_cnt_n = 3'd0;
            if (state_r == ADDR_ACK && rx_r[0]) begin
              state_n = RDATA;
              tx_n    = rd_cur_s;
              oe_n    = ~rd_cur_s[7];
            end else if (state_r == ADDR_ACK) begin
              state_n = PTR;
            end else if (state_r == WDATA_ACK) begin
              ptr_n   = ptr_r + 3'd1;
              state_n = WDATA;
            end else begin
              state_n = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise_s) begin
            bit_cnt_n = bit_cnt_r + 3'd1;
            tx_n      = {tx_r[6:0], 1'b0};
          end else if (scl_fall_s && bit_cnt_r == 3'd0) begin
            oe_n       = 1'b0;
            state_n    = RACK;
            flag_clr_s = (ptr_r == 3'd3);
          end else if (scl_fall_s) begin
            oe_n = ~tx_r[7];
          end else begin
            state_n = state_r;
          end
        end
        RACK: begin
          if (scl_rise_s && sda_f_r) begin
            state_n = IDLE;
          end else if (scl_fall_s) begin
            ptr_n   = ptr_r + 3'd1;
            tx_n    = rd_nxt_s;
            oe_n    = ~rd_nxt_s[7];
            state_n = RDATA;
          end else begin
            state_n = state_r;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // FSM state, byte datapath, busy and host-writable registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      ptr_r      <= 3'd0;
      bit_cnt_r  <= 3'd0;
      rx_r       <= 8'h00;
      tx_r       <= 8'h00;
      config_r   <= 3'b000;
      override_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      sda_oe_r  <= oe_n;
      ptr_r     <= ptr_n;
      bit_cnt_r <= bit_cnt_n;
      rx_r      <= rx_n;
      tx_r      <= tx_n;
      if (state_n == ADDR_ACK) begin
        busy_r <= 1'b1;
      end else if (state_n == IDLE) begin
        busy_r <= 1'b0;
      end
      if (wr_en_s) begin
        case (ptr_r)
          3'd4:    config_r   <= rx_byte_s[2:0];
          3'd5:    override_r <= rx_byte_s[0];
          default: ;
        endcase
      end
    end
  end

  // The read freeze starts at the read-address ACK so the first byte is already coherent
  assign freeze_s = (state_r == RDATA) || (state_r == RACK) || ((state_r == ADDR_ACK) && rx_r[0]);

  // Measurement shadow, deferred update during reads, and new-result flag (set beats clear)
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_r    <= 20'h00000;
      pend_data_r <= 20'h00000;
      pend_r      <= 1'b0;
      flag_r      <= 1'b0;
    end else if (result_valid && !freeze_s) begin
      shadow_r <= result_bcd;
      pend_r   <= 1'b0;
      flag_r   <= 1'b1;
    end else if (result_valid) begin
      pend_data_r <= result_bcd;
      pend_r      <= 1'b1;
      if (flag_clr_s) begin
        flag_r <= 1'b0;
      end
    end else if (pend_r && !freeze_s) begin
      shadow_r <= pend_data_r;
      pend_r   <= 1'b0;
      flag_r   <= 1'b1;
    end else if (flag_clr_s) begin
      flag_r <= 1'b0;
    end
  end

  assign sda_oe          = sda_oe_r;
  assign busy            = busy_r;
  assign config_out      = config_r;
  assign config_override = override_r;

endmodule

// File: tb/tb_i2c_result_target.sv
// Bench for i2c_result_target: a bit-banged I2C master on a wired-AND SDA line,
// with expected ACKs, read bytes and status pushed to a scoreboard queue before each transaction.
`timescale 1ns/1ps
module tb_i2c_result_target;

  localparam int T          = 10;
  localparam int FILTER_LEN = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        scl_m, sda_m, sda_line;
  logic        sda_oe;
  logic        result_valid;
  logic [19:0] result_bcd;
  logic [2:0]  config_out;
  logic        config_override;
  logic        busy;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_q[$];
  logic        ack_n;
  logic [7:0]  rd_b;

  assign sda_line = sda_m & ~sda_oe;

  i2c_result_target #(
    .I2C_ADDR  (7'h2A),
    .FILTER_LEN(FILTER_LEN),
    .DEVICE_ID (8'h54)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .scl_in         (scl_m),
    .sda_in         (sda_line),
    .sda_oe         (sda_oe),
    .result_valid   (result_valid),
    .result_bcd     (result_bcd),
    .config_out     (config_out),
    .config_override(config_override),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic expect_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 32'hDEAD_BEEF;
    check_value(tag, obs, e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl_m = 1'b1; cycles(T);
    sda_m = 1'b0; cycles(T);
    scl_m = 1'b0; cycles(T);
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; cycles(T);
    scl_m = 1'b1; cycles(T);
    sda_m = 1'b0; cycles(T);
    scl_m = 1'b0; cycles(T);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; cycles(T);
    scl_m = 1'b1; cycles(T);
    sda_m = 1'b1; cycles(T);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; cycles(T);
    scl_m = 1'b1; cycles(T);
    scl_m = 1'b0; cycles(T);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; cycles(T);
    scl_m = 1'b1; cycles(T / 2);
    ack = sda_line;
    cycles(T / 2);
    scl_m = 1'b0; cycles(T);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; cycles(T);
      scl_m = 1'b1; cycles(T / 2);
      b[i] = sda_line;
      cycles(T / 2);
      scl_m = 1'b0; cycles(T);
    end
    sda_m = nack; cycles(T);
    scl_m = 1'b1; cycles(T);
    scl_m = 1'b0; cycles(T);
    sda_m = 1'b1;
  endtask

  task automatic pulse_result(input logic [19:0] v);
    result_bcd   = v;
    result_valid = 1'b1;
    cycles(1);
    result_valid = 1'b0;
    cycles(2);
  endtask

  // Set the pointer, repeated START, read n bytes (NACK on the last); optional result pulse before byte pulse_idx
  task automatic read_regs(input logic [2:0] ptr, input int n, input int pulse_idx, input logic [19:0] pv);
    logic       a;
    logic [7:0] b;
    bus_start();
    send_byte(8'h54, a);         expect_pop("rd_addr_w_ack", a);
    send_byte({5'h00, ptr}, a);  expect_pop("rd_ptr_ack", a);
    bus_rstart();
    send_byte(8'h55, a);         expect_pop("rd_addr_r_ack", a);
    for (int k = 0; k < n; k++) begin
      if (k == pulse_idx) pulse_result(pv);
      recv_byte(k == n - 1, b);
      expect_pop($sformatf("rd_byte%0d", k), b);
    end
    bus_stop();
  endtask

  initial begin
    #900_000;
    check_value("watchdog", 32'd1, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    scl_m        = 1'b1;
    sda_m        = 1'b1;
    result_valid = 1'b0;
    result_bcd   = 20'h00000;
    cycles(5);
    reset = 1'b0;
    cycles(T);
    check_value("rst_sda_oe",   sda_oe,          32'd0);
    check_value("rst_busy",     busy,            32'd0);
    check_value("rst_config",   config_out,      32'd0);
    check_value("rst_override", config_override, 32'd0);

    // Write 0x05, 0x01 to registers 4 and 5
    expect_push(32'd0); expect_push(32'd1);
    expect_push(32'd0); expect_push(32'd0); expect_push(32'd0);
    bus_start();
    send_byte(8'h54, ack_n); expect_pop("wr_addr_ack", ack_n);
    expect_pop("wr_busy", busy);
    send_byte(8'h04, ack_n); expect_pop("wr_ptr_ack", ack_n);
    send_byte(8'h05, ack_n); expect_pop("wr_d0_ack", ack_n);
    send_byte(8'h01, ack_n); expect_pop("wr_d1_ack", ack_n);
    bus_stop();
    check_value("wr_config",   config_out,      32'd5);
    check_value("wr_override", config_override, 32'd1);
    check_value("wr_busy_end", busy,            32'd0);

    // Coherent read of a fresh result, then register 3 again to see the cleared flag
    pulse_result(20'h12345);
    expect_push(32'd0); expect_push(32'd0); expect_push(32'd0);
    expect_push(32'h45); expect_push(32'h23); expect_push(32'h01); expect_push(32'h01);
    read_regs(3'd0, 4, -1, 20'h00000);
    expect_push(32'd0); expect_push(32'd0); expect_push(32'd0); expect_push(32'h00);
    read_regs(3'd3, 1, -1, 20'h00000);

    // Result arriving during byte 1 of the read is deferred until the read ends
    pulse_result(20'h12345);
    expect_push(32'd0); expect_push(32'd0); expect_push(32'd0);
    expect_push(32'h45); expect_push(32'h23); expect_push(32'h01); expect_push(32'h01);
    read_regs(3'd0, 4, 1, 20'h00999);
    expect_push(32'd0); expect_push(32'd0); expect_push(32'd0);
    expect_push(32'h99); expect_push(32'h09); expect_push(32'h00); expect_push(32'h01);
    read_regs(3'd0, 4, -1, 20'h00000);

    // Device ID and the wrap from 7 back to 0
    expect_push(32'd0); expect_push(32'd0); expect_push(32'd0);
    expect_push(32'h54); expect_push(32'h00); expect_push(32'h99);
    read_regs(3'd6, 3, -1, 20'h00000);

    // Address mismatch: no ACK, following bytes ignored
    expect_push(32'd1); expect_push(32'd1); expect_push(32'd0);
    bus_start();
    send_byte(8'h56, ack_n); expect_pop("mm_addr_nack", ack_n);
    send_byte(8'h04, ack_n); expect_pop("mm_data_nack", ack_n);
    expect_pop("mm_busy", busy);
    bus_stop();

    // Short SDA glitch while SCL high must not start a transaction
    expect_push(32'd1); expect_push(32'd0);
    scl_m = 1'b1; sda_m = 1'b1; cycles(T);
    sda_m = 1'b0; cycles(FILTER_LEN - 1);
    sda_m = 1'b1; cycles(T);
    scl_m = 1'b0; cycles(T);
    send_byte(8'h54, ack_n); expect_pop("glitch_short_nack", ack_n);
    expect_pop("glitch_short_busy", busy);
    // A FILTER_LEN-cycle low is a real START
    expect_push(32'd0); expect_push(32'd1);
    sda_m = 1'b1; cycles(T);
    scl_m = 1'b1; cycles(T);
    sda_m = 1'b0; cycles(FILTER_LEN);
    scl_m = 1'b0; cycles(T);
    send_byte(8'h54, ack_n); expect_pop("glitch_len_ack", ack_n);
    expect_pop("glitch_len_busy", busy);
    bus_stop();

    // Reset during the 4th data bit of a write to register 4
    expect_push(32'd0); expect_push(32'd0); expect_push(32'd5);
    bus_start();
    send_byte(8'h54, ack_n); expect_pop("rw_addr_ack", ack_n);
    send_byte(8'h04, ack_n); expect_pop("rw_ptr_ack", ack_n);
    expect_pop("rw_cfg_before", config_out);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    sda_m = 1'b1; cycles(T);
    scl_m = 1'b1; cycles(T / 2);
    reset = 1'b1; cycles(1);
    reset = 1'b0;
    check_value("rw_sda_oe", sda_oe,     32'd0);
    check_value("rw_config", config_out, 32'd0);
    check_value("rw_busy",   busy,       32'd0);
    cycles(T);
    scl_m = 1'b0; cycles(T);
    expect_push(32'd1);
    send_byte(8'h54, ack_n); expect_pop("rw_idle_nack", ack_n);
    bus_stop();

    check_value("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
